trace_buffer: RTL
=================

# trace_buffer

Parametrised hardware trace capture for the single-cycle CPU: records up to `CHANNELS` watched values (e.g. PC, a register-file entry) on each qualified cycle into a circular buffer. An optional trigger compare on channel 0 freezes the buffer a fixed number of samples after the match. Sits beside `top`, fed from core probe wires. Frozen history is read back through a random-access port, ordered oldest to newest. This replaces per-cycle `$display` tracing with synthesisable, parameter-scaled capture.

## Interface
- `WIDTH`, 32, bits per channel
- `CHANNELS`, 2, number of probed values; channel 0 is the trigger channel
- `DEPTH`, 16, samples held; power of two, ≥2
- `POST`, 8, samples captured after (not including) the trigger sample; 0..DEPTH-1
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `sample_valid`  in  1  current `sample_data` is a sample (e.g. instruction retire)
- `sample_data`  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- `trig_value`  in  WIDTH  trigger compare value for channel 0
- `arm`  in  1  single-cycle pulse: clear and start capture
- `rd_addr`  in  log2(DEPTH)  read index, 0 = oldest held sample
- `rd_data`  out  CHANNELS*WIDTH  registered read data
- `armed`  out  1  state is ARMED or POST
- `triggered`  out  1  state is POST or DONE
- `done`  out  1  state is DONE
- `count`  out  log2(DEPTH)+1  samples held, saturates at DEPTH

## Operation
- State machine: IDLE, ARMED, POST, DONE; registered state.
- IDLE: no writes. `arm` → ARMED, `wr_ptr`=0, `count`=0.
- ARMED: each `sample_valid` writes `sample_data` at `wr_ptr`; `wr_ptr` advances mod DEPTH (wrap overwrites oldest); `count` increments, saturating at DEPTH.
- Trigger: `sample_valid` with channel 0 == `trig_value` in ARMED. Trigger sample is written. POST==0 → DONE; else → POST with `remaining`=POST.
- POST: each valid sample is written and decrements `remaining`; the write that takes it to 0 moves to DONE. Cycles with `sample_valid`=0 write nothing.
- Channel-0 matches in POST are ignored; no re-trigger.
- DONE: buffer frozen; samples ignored. `arm` → ARMED (restart).
- `arm` in ARMED or POST: restart; `wr_ptr`/`count` clear and any same-cycle sample is dropped. `arm` has priority over a same-cycle trigger.
- Read: physical index = (`wr_ptr` − `count` + `rd_addr`) mod DEPTH. `rd_addr` ≥ `count` returns all zeros. Reads are valid in every state; a read concurrent with a write returns the old content.
- Storage is not reset.

## Timing
- Reset (`rst_n`=0 at a rising edge): state IDLE; `armed`/`triggered`/`done`=0; `count`=0; `rd_data`=0; `wr_ptr`=0. Applies mid-capture as well: partial capture is discarded.
- Sample written on the edge where `sample_valid`=1; `count` updates on the same edge.
- `done` rises on the edge that writes the final POST sample, i.e. it is visible the cycle after that sample is presented.
- `rd_data` latency: 1 cycle after `rd_addr`.
- `armed` goes high the cycle after the `arm` pulse.

## Configuration
- `TRACE_TRIGGER_EN` defined: channel-0 compare against `trig_value`, as above.
- `TRACE_TRIGGER_EN` undefined: no comparator; `trig_value` is ignored. The first valid sample after arming is the trigger sample (one-shot capture of POST+1 samples); all other behaviour is unchanged.

## Test plan
All scenarios use WIDTH=32, CHANNELS=2, DEPTH=8, POST=3, macro defined unless noted.
- Reset held with `sample_valid`=1 and random data → `count`=0, `armed`=0, `done`=0, `rd_data`=0.
- Arm with `trig_value`=0x14, feed ch0=0x00,0x04,…,0x20 (9 samples, ch1 = ch0+1) → `done`=1 the cycle after 0x20, `count`=8; `rd_addr` 0 → ch0 0x04/ch1 0x05; `rd_addr` 7 → ch0 0x20.
- Same run, `sample_valid` low on alternate cycles during POST, ch0=0x14 repeated in POST → exactly 3 post samples captured, no re-trigger.
- After DONE, further samples leave `rd_data` unchanged. Then `arm` → `count`=0, `done`=0, `rd_addr` 0 returns 0.
- `rst_n` low mid-POST → next cycle IDLE, `count`=0, `triggered`=0.
- Macro undefined, arm, feed 0xA0,0xA1,0xA2,0xA3,0xA4 → DONE after 0xA3, `count`=4, 0xA4 not stored.

Source files
------------

// File: rtl/trace_buffer.sv
// trace_buffer: circular multi-channel trace capture, frozen a fixed number of samples after a trigger.
// TRACE_TRIGGER_EN enables the channel-0 compare; without it the first sample after arming triggers.
module trace_buffer #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 16,
    parameter int POST     = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_sample_valid,
    input  logic [CHANNELS*WIDTH-1:0]     i_sample_data,
    input  logic [WIDTH-1:0]              i_trig_value,
    input  logic                          i_arm,
    input  logic [$clog2(DEPTH)-1:0]      i_rd_addr,
    output logic [CHANNELS*WIDTH-1:0]     o_rd_data,
    output logic                          o_armed,
    output logic                          o_triggered,
    output logic                          o_done,
    output logic [$clog2(DEPTH):0]        o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = CHANNELS * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [AW-1:0]   r_wr_ptr, r_remaining, w_phys;
    logic [AW:0]     r_count;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [DW-1:0]   r_rd_data;
    logic            w_hit, w_wr, w_last;

`ifdef TRACE_TRIGGER_EN
    assign w_hit = i_sample_data[WIDTH-1:0] == i_trig_value;
`else
    logic w_unused_trig;
    assign w_unused_trig = ^i_trig_value;
    assign w_hit = 1'b1;
`endif

    // A same-cycle arm wins: the sample is dropped and the capture restarts.
    assign w_wr   = i_rst_n && i_sample_valid && !i_arm && (r_state == S_ARMED || r_state == S_POST);
    assign w_last = r_remaining == AW'(1);
    assign w_phys = r_wr_ptr - r_count[AW-1:0] + i_rd_addr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = i_arm ? S_ARMED :
                 (w_wr && r_state == S_ARMED && w_hit) ? ((POST == 0) ? S_DONE : S_POST) :
                 (w_wr && r_state == S_POST && w_last) ? S_DONE : r_state;
    end

    always_comb begin
        o_armed     = r_state == S_ARMED || r_state == S_POST;
        o_triggered = r_state == S_POST || r_state == S_DONE;
        o_done      = r_state == S_DONE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_rd_data   <= '0;
        end else begin
            r_rd_data <= ({1'b0, i_rd_addr} < r_count) ? r_mem[w_phys] : '0;
            if (i_arm) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_count  <= (r_count == (AW+1)'(DEPTH)) ? r_count : r_count + (AW+1)'(1);
            end
            if (w_wr) r_remaining <= (r_state == S_ARMED) ? AW'(POST) : r_remaining - AW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_sample_data;
    end

    assign o_rd_data = r_rd_data;
    assign o_count   = r_count;
endmodule
